pwm_fade_ctrl: RTL and testbench
================================

// Module: pwm_fade_ctrl
// PURPOSE
//  Bus master that sequences the PWM CSR block: programs divisor, period and ctrl, then ramps
//  duty_cycle from its last programmed value to a target in fixed steps at a fixed interval.
//  Sits between the host CSR port and the PWM CSR slave and shares that slave's bus with the host.
//  Host accesses take priority; a stall limit guarantees the fade engine makes progress.
// PARAMETERS
//  HOST_MAX_STALL  4   max consecutive contested cycles host may win before engine gets one cycle
// PORTS
//  clk          in   1   clock
//  reset        in   1   reset, asynchronous, active-high
//  start        in   1   pulse: begin sequence (ignored while busy)
//  abort        in   1   pulse: stop sequence, return to IDLE
//  cfg_divisor  in   16  divisor value written at start
//  cfg_period   in   16  period value written at start
//  cfg_ctrl     in   8   ctrl value written at start
//  target_duty  in   16  final duty; clamped to cfg_period
//  step         in   16  duty increment per write; 0 = jump to target in one write
//  interval     in   16  idle cycles between duty writes
//  host_cs/host_we/host_re  in 1 each   host bus strobes
//  host_addr    in   16  host address;  host_wdata in 16 host write data
//  host_rdata   out  16  = csr_rdata when host granted, else 0
//  csr_cs/csr_we/csr_re     out 1 each   to PWM CSR slave
//  csr_addr     out  16;  csr_wdata out 16;  csr_rdata in 16
//  busy         out  1   high outside IDLE
//  done         out  1   one-cycle pulse when final duty write completes
//  cur_duty     out  16  last duty value written by engine
// BEHAVIOUR
//  - Reset: state IDLE; busy, done, csr_* strobes 0; csr_addr/wdata 0; cur_duty 0; stall count 0.
//  - CSR slave write is single-cycle: a write is complete in the cycle the strobe is driven.
//  - Address map: CTRL=0, DIVISOR=2, PERIOD=4, DUTY=6.
//  - FSM: IDLE -start-> W_DIV -> W_PER -> W_CTRL -> W_DUTY -> (dutyplus==tgt ? DONE : WAIT).
//    WAIT -(interval cycles elapsed)-> W_DUTY.  DONE: pulse done for 1 cycle -> IDLE.
//  - Each W_* state holds until granted; a granted W_* state drives csr_cs=csr_we=1 for exactly
//    1 cycle, then advances.
//  - start latches all cfg_* inputs; tgt = min(target_duty, cfg_period).
//  - Next duty (17-bit arithmetic):
//    cur<tgt: min(cur+step, tgt); cur>tgt: max(cur-step, tgt) with no underflow below tgt;
//    step==0 or cur==tgt: tgt.
//    cur_duty updates in the cycle the write is issued.
//  - cur==tgt at start: exactly one duty write of tgt, then DONE.
//  - Write latency from start with an idle host bus: DIV write at cycle +1, PER at +2, CTRL at +3,
//    first DUTY at +4. Each subsequent DUTY write occurs interval+1 cycles after the previous one.
//    interval=0 gives back-to-back duty writes.
//  - Arbitration is host-first:
//    - If host_cs and the engine requests in the same cycle, the host is granted and the stall
//      count increments.
//    - When stall count == HOST_MAX_STALL, the engine is granted that cycle; the host sees no
//      access (host must hold its strobes) and the count clears.
//    - Any engine grant clears the count.
//    - WAIT and IDLE never request.
//  - abort in any non-IDLE state: the next state is IDLE. No write is issued in the abort cycle.
//    done is not pulsed and cur_duty keeps its last written value.
//  - start and abort in the same cycle: abort wins (remain IDLE). start while busy is ignored.
//  - Asynchronous reset mid-sequence: immediate return to reset values; no partial write persists.
// CONFIGURATION
//  - PWM_FADE_IRQ_EN defined: adds ports irq (out, 1) and irq_clr (in, 1).
//    - irq sets on done and is sticky; it clears on irq_clr.
//    - If set and clear coincide, set wins.
//    - irq resets to 0.
//  - Not defined: no irq logic or ports.
// STRUCTURE
//  - pwm_pkg: CSR address constants (ADDR_CTRL/DIVISOR/PERIOD/DUTY_CYCLE), FSM state typedef
//    {IDLE, W_DIV, W_PER, W_CTRL, W_DUTY, WAIT, DONE}.
//  - Sub-module pwm_bus_arb: 2:1 host/engine mux with stall counter, outputs grant_eng/grant_host.
//  - Top: FSM, duty stepper, interval counter.
// TESTING
//  1. Reset, then start with div=10, per=100, ctrl=0x01, tgt=40, step=10, interval=3, idle host
//     -> writes DIV(10), PER(100), CTRL(1), DUTY 10, 20, 30, 40, each DUTY 4 cycles apart;
//     done pulses once; cur_duty=40.
//  2. From cur=40: tgt=15, step=10 -> duty writes 30, 20, 15; done pulses.
//  3. tgt=500, per=100 -> duty ramps clamped; final write 100.
//  4. Host holds host_cs=1 continuously during W_PER with HOST_MAX_STALL=4 -> host granted 4 cycles,
//     engine PER write on cycle 5, host regranted after.
//  5. Abort during WAIT after duty 20 -> IDLE next cycle, no further csr writes, done stays 0,
//     cur_duty=20. Start+abort together -> stays IDLE.
//  6. Assert reset mid W_DUTY -> all outputs 0 immediately.
//     PWM_FADE_IRQ_EN: irq sticky after done, cleared by irq_clr; simultaneous set/clr -> irq=1.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM fade controller.
// CSR address map and fade sequencer state encoding.
package pwm_pkg;

  localparam logic [15:0] ADDR_CTRL       = 16'd0;
  localparam logic [15:0] ADDR_DIVISOR    = 16'd2;
  localparam logic [15:0] ADDR_PERIOD     = 16'd4;
  localparam logic [15:0] ADDR_DUTY_CYCLE = 16'd6;

  typedef enum logic [2:0] {
    IDLE,
    W_DIV,
    W_PER,
    W_CTRL,
    W_DUTY,
    WAIT,
    DONE
  } fade_state_t;

endpackage

// File: rtl/pwm_bus_arb.sv
// Host-first 2:1 mux onto the PWM CSR slave bus.
// A stall counter forces one engine grant after HOST_MAX_STALL lost contests.
module pwm_bus_arb #(
  parameter int HOST_MAX_STALL = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        eng_req,
  input  logic [15:0] eng_addr,
  input  logic [15:0] eng_wdata,
  input  logic        host_cs,
  input  logic        host_we,
  input  logic        host_re,
  input  logic [15:0] host_addr,
  input  logic [15:0] host_wdata,
  input  logic [15:0] csr_rdata,
  output logic        csr_cs,
  output logic        csr_we,
  output logic        csr_re,
  output logic [15:0] csr_addr,
  output logic [15:0] csr_wdata,
  output logic [15:0] host_rdata,
  output logic        grant_eng,
  output logic        grant_host
);

  localparam int SW = $clog2(HOST_MAX_STALL + 2);

  logic [SW-1:0] stall;
  logic          limit;

  assign limit      = (int'(stall) >= HOST_MAX_STALL);
  assign grant_eng  = eng_req & (~host_cs | limit);
  assign grant_host = host_cs & ~grant_eng;

  always_comb begin
    csr_cs     = 1'b0;
    csr_we     = 1'b0;
    csr_re     = 1'b0;
    csr_addr   = '0;
    csr_wdata  = '0;
    host_rdata = '0;
    unique case (1'b1)
      grant_eng: begin
        csr_cs    = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = eng_addr;
        csr_wdata = eng_wdata;
      end
      grant_host: begin
        csr_cs     = 1'b1;
        csr_we     = host_we;
        csr_re     = host_re;
        csr_addr   = host_addr;
        csr_wdata  = host_wdata;
        host_rdata = csr_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall <= '0;
    else if (grant_eng)
      stall <= '0;
    else if (eng_req & host_cs)
      stall <= stall + 1'b1;
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// PWM fade sequencer: programs divisor/period/ctrl, then steps duty to a target.
// Optional sticky completion interrupt when PWM_FADE_IRQ_EN is defined.
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int HOST_MAX_STALL = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] cfg_divisor,
  input  logic [15:0] cfg_period,
  input  logic [7:0]  cfg_ctrl,
  input  logic [15:0] target_duty,
  input  logic [15:0] step,
  input  logic [15:0] interval,
  input  logic        host_cs,
  input  logic        host_we,
  input  logic        host_re,
  input  logic [15:0] host_addr,
  input  logic [15:0] host_wdata,
  output logic [15:0] host_rdata,
  output logic        csr_cs,
  output logic        csr_we,
  output logic        csr_re,
  output logic [15:0] csr_addr,
  output logic [15:0] csr_wdata,
  input  logic [15:0] csr_rdata,
`ifdef PWM_FADE_IRQ_EN
  output logic        irq,
  input  logic        irq_clr,
`endif
  output logic        busy,
  output logic        done,
  output logic [15:0] cur_duty
);

  fade_state_t state, state_n;

  logic [15:0] div_q, per_q, tgt_q, step_q, ivl_q, cnt;
  logic [7:0]  ctrl_q;
  logic [15:0] next_duty, eng_addr, eng_wdata;
  logic [16:0] sum;
  logic        eng_req, grant_eng, grant_host, launch;

  assign launch = (state == IDLE) & start & ~abort;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE) & ~abort;

  // Saturating step toward the target; never overshoots in either direction.
  always_comb begin
    sum = {1'b0, cur_duty} + {1'b0, step_q};
    next_duty = tgt_q;
    if (step_q != 16'd0 && cur_duty != tgt_q) begin
      if (cur_duty < tgt_q)
        next_duty = (sum > {1'b0, tgt_q}) ? tgt_q : sum[15:0];
      else
        next_duty = (step_q >= cur_duty - tgt_q) ?
                    tgt_q : cur_duty - step_q;
    end
  end

  always_comb begin
    eng_req   = 1'b0;
    eng_addr  = '0;
    eng_wdata = '0;
    unique case (state)
      W_DIV: begin
        eng_req   = 1'b1;
        eng_addr  = ADDR_DIVISOR;
        eng_wdata = div_q;
      end
      W_PER: begin
        eng_req   = 1'b1;
        eng_addr  = ADDR_PERIOD;
        eng_wdata = per_q;
      end
      W_CTRL: begin
        eng_req   = 1'b1;
        eng_addr  = ADDR_CTRL;
        eng_wdata = {8'h00, ctrl_q};
      end
      W_DUTY: begin
        eng_req   = 1'b1;
        eng_addr  = ADDR_DUTY_CYCLE;
        eng_wdata = next_duty;
      end
      default: ;
    endcase
    if (abort)
      eng_req = 1'b0;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (start) state_n = W_DIV;
      W_DIV:  if (grant_eng) state_n = W_PER;
      W_PER:  if (grant_eng) state_n = W_CTRL;
      W_CTRL: if (grant_eng) state_n = W_DUTY;
      W_DUTY: begin
        if (grant_eng) begin
          if (next_duty == tgt_q)
            state_n = DONE;
          else if (ivl_q == 16'd0)
            state_n = W_DUTY;
          else
            state_n = WAIT;
        end
      end
      WAIT: begin
        if ({1'b0, cnt} + 17'd1 == {1'b0, ivl_q})
          state_n = W_DUTY;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort)
      state_n = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      per_q  <= '0;
      ctrl_q <= '0;
      tgt_q  <= '0;
      step_q <= '0;
      ivl_q  <= '0;
    end else if (launch) begin
      div_q  <= cfg_divisor;
      per_q  <= cfg_period;
      ctrl_q <= cfg_ctrl;
      tgt_q  <= (target_duty > cfg_period) ?
                cfg_period : target_duty;
      step_q <= step;
      ivl_q  <= interval;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (state == WAIT)
      cnt <= cnt + 16'd1;
    else
      cnt <= '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cur_duty <= '0;
    else if (state == W_DUTY && grant_eng)
      cur_duty <= next_duty;
  end

`ifdef PWM_FADE_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      irq <= 1'b0;
    else if (done)
      irq <= 1'b1;
    else if (irq_clr)
      irq <= 1'b0;
  end
`endif

  pwm_bus_arb #(
    .HOST_MAX_STALL(HOST_MAX_STALL)
  ) u_arb (
    .clk        (clk),
    .reset      (reset),
    .eng_req    (eng_req),
    .eng_addr   (eng_addr),
    .eng_wdata  (eng_wdata),
    .host_cs    (host_cs),
    .host_we    (host_we),
    .host_re    (host_re),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .csr_rdata  (csr_rdata),
    .csr_cs     (csr_cs),
    .csr_we     (csr_we),
    .csr_re     (csr_re),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
    .host_rdata (host_rdata),
    .grant_eng  (grant_eng),
    .grant_host (grant_host)
  );

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl: schedule model plus directed checks.
// Irq checks are compiled in when PWM_FADE_IRQ_EN is defined.
module tb_pwm_fade_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic [15:0] cfg_divisor = '0, cfg_period = '0;
  logic [7:0]  cfg_ctrl = '0;
  logic [15:0] target_duty = '0, step = '0, interval = '0;
  logic        host_cs = 1'b0, host_we = 1'b0, host_re = 1'b0;
  logic [15:0] host_addr = '0, host_wdata = '0;
  logic [15:0] host_rdata;
  logic        csr_cs, csr_we, csr_re;
  logic [15:0] csr_addr, csr_wdata;
  logic [15:0] csr_rdata = 16'hBEEF;
  logic        busy, done;
  logic [15:0] cur_duty;
`ifdef PWM_FADE_IRQ_EN
  logic        irq;
  logic        irq_clr = 1'b0;
`endif

  pwm_fade_ctrl #(.HOST_MAX_STALL(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .cfg_divisor (cfg_divisor),
    .cfg_period  (cfg_period),
    .cfg_ctrl    (cfg_ctrl),
    .target_duty (target_duty),
    .step        (step),
    .interval    (interval),
    .host_cs     (host_cs),
    .host_we     (host_we),
    .host_re     (host_re),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .csr_cs      (csr_cs),
    .csr_we      (csr_we),
    .csr_re      (csr_re),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
`ifdef PWM_FADE_IRQ_EN
    .irq         (irq),
    .irq_clr     (irq_clr),
`endif
    .busy        (busy),
    .done        (done),
    .cur_duty    (cur_duty)
  );

  initial forever #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  int cyc = 0;
  int ndone = 0;
  bit chk_en = 1'b0;

  // Expected write schedule keyed by absolute cycle number.
  logic [15:0] exp_addr [int];
  logic [15:0] exp_data [int];
  int duties[$];
  int done_at = -1, busy_from = -1, busy_to = -2;
  int model_cur = 0;
  bit exp_wr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, expv, cyc);
    end
  endtask

  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic plan(int s, int dv, int pr, int ct,
                      int tg, int st, int iv);
    int t, c, n, w;
    exp_addr.delete();
    exp_data.delete();
    duties.delete();
    t = (tg > pr) ? pr : tg;
    exp_addr[s+1] = 16'd2; exp_data[s+1] = 16'(dv);
    exp_addr[s+2] = 16'd4; exp_data[s+2] = 16'(pr);
    exp_addr[s+3] = 16'd0; exp_data[s+3] = 16'(ct);
    c = model_cur;
    w = s + 4;
    while (1) begin
      if (st == 0 || c == t) n = t;
      else if (c < t) n = (c + st > t) ? t : c + st;
      else n = (c - st < t) ? t : c - st;
      exp_addr[w] = 16'd6;
      exp_data[w] = 16'(n);
      duties.push_back(n);
      c = n;
      if (n == t) break;
      w += iv + 1;
    end
    busy_from = s + 1;
    done_at = w + 1;
    busy_to = w + 1;
    model_cur = c;
  endtask

  // Abort observed in cycle a: nothing from a onward, no done.
  task automatic truncate(int a);
    model_cur = model_cur;
    for (int k = busy_from; k < a; k++)
      if (exp_addr.exists(k) && exp_addr[k] == 16'd6)
        model_cur = int'(exp_data[k]);
    for (int k = a; k <= busy_to; k++)
      if (exp_addr.exists(k)) begin
        exp_addr.delete(k);
        exp_data.delete(k);
      end
    done_at = -1;
    busy_to = a;
  endtask

  always @(negedge clk) begin
    if (!reset && done) ndone++;
    if (chk_en && !reset) begin
      exp_wr = exp_addr.exists(cyc) != 0;
      chk("csr_cs", 32'(csr_cs), 32'(exp_wr));
      if (exp_wr) begin
        chk("csr_we", 32'(csr_we), 32'd1);
        chk("csr_addr", 32'(csr_addr), 32'(exp_addr[cyc]));
        chk("csr_wdata", 32'(csr_wdata), 32'(exp_data[cyc]));
      end
      chk("busy", 32'(busy),
          32'(cyc >= busy_from && cyc <= busy_to));
      chk("done", 32'(done), 32'(cyc == done_at));
    end
  end

  task automatic run(int dv, int pr, int ct, int tg,
                     int st, int iv, bit clr);
    int guard;
    cfg_divisor = 16'(dv);
    cfg_period = 16'(pr);
    cfg_ctrl = 8'(ct);
    target_duty = 16'(tg);
    step = 16'(st);
    interval = 16'(iv);
    start = 1'b1;
    plan(cyc, dv, pr, ct, tg, st, iv);
    step_cyc();
    start = 1'b0;
`ifdef PWM_FADE_IRQ_EN
    irq_clr = clr;
`endif
    guard = 0;
    while (cyc < done_at + 1 && guard < 2000) begin
      step_cyc();
      guard++;
    end
    if (guard >= 2000) chk("run_timeout", 32'd1, 32'd0);
    @(negedge clk);
    chk("cur_duty_end", 32'(cur_duty), 32'(model_cur));
`ifdef PWM_FADE_IRQ_EN
    if (clr) chk("irq_set_wins", 32'(irq), 32'd1);
    irq_clr = 1'b0;
`endif
    step_cyc();
  endtask

  initial begin
    int d0, s;
    int lit1[4] = '{10, 20, 30, 40};
    int lit2[3] = '{30, 20, 15};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cs", 32'(csr_cs), 32'd0);
    chk("rst_we", 32'(csr_we), 32'd0);
    chk("rst_addr", 32'(csr_addr), 32'd0);
    chk("rst_wdata", 32'(csr_wdata), 32'd0);
    chk("rst_cur", 32'(cur_duty), 32'd0);
`ifdef PWM_FADE_IRQ_EN
    chk("rst_irq", 32'(irq), 32'd0);
`endif
    step_cyc();
    reset = 1'b0;
    step_cyc();
    chk_en = 1'b1;

    // 1: basic ramp up
    d0 = ndone;
    run(10, 100, 1, 40, 10, 3, 1'b0);
    chk("t1_ndup", 32'(duties.size()), 32'd4);
    foreach (lit1[i]) chk("t1_model", 32'(duties[i]), 32'(lit1[i]));
    chk("t1_cur", 32'(cur_duty), 32'd40);
    chk("t1_done_cnt", 32'(ndone - d0), 32'd1);
`ifdef PWM_FADE_IRQ_EN
    chk("irq_sticky", 32'(irq), 32'd1);
    irq_clr = 1'b1;
    step_cyc();
    irq_clr = 1'b0;
    @(negedge clk);
    chk("irq_cleared", 32'(irq), 32'd0);
    step_cyc();
`endif

    // 2: ramp down with non-multiple step; clear collides with done
    d0 = ndone;
    run(10, 100, 1, 15, 10, 2, 1'b1);
    chk("t2_ndup", 32'(duties.size()), 32'd3);
    foreach (lit2[i]) chk("t2_model", 32'(duties[i]), 32'(lit2[i]));
    chk("t2_cur", 32'(cur_duty), 32'd15);
    chk("t2_done_cnt", 32'(ndone - d0), 32'd1);

    // 3: target above period clamps, back-to-back writes
    run(3, 100, 2, 500, 30, 0, 1'b0);
    chk("t3_cur", 32'(cur_duty), 32'd100);

    // 4: host holds the bus during the period write
    chk_en = 1'b0;
    cfg_period = 16'd77;
    start = 1'b1;
    s = cyc;
    step_cyc();
    start = 1'b0;
    step_cyc();
    host_cs = 1'b1;
    host_re = 1'b1;
    host_addr = 16'd8;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arb_host_re", 32'(csr_re), 32'd1);
      chk("arb_host_we", 32'(csr_we), 32'd0);
      chk("arb_host_addr", 32'(csr_addr), 32'd8);
      chk("arb_host_rdata", 32'(host_rdata), 32'hBEEF);
      step_cyc();
    end
    @(negedge clk);
    chk("arb_eng_cyc", 32'(cyc - s), 32'd6);
    chk("arb_eng_we", 32'(csr_we), 32'd1);
    chk("arb_eng_addr", 32'(csr_addr), 32'd4);
    chk("arb_eng_data", 32'(csr_wdata), 32'd77);
    chk("arb_eng_rdata", 32'(host_rdata), 32'd0);
    step_cyc();
    @(negedge clk);
    chk("arb_regrant_re", 32'(csr_re), 32'd1);
    chk("arb_regrant_addr", 32'(csr_addr), 32'd8);
    step_cyc();
    host_cs = 1'b0;
    host_re = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_no_write", 32'(csr_cs), 32'd0);
    chk("abort_no_done", 32'(done), 32'd0);
    step_cyc();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_cur", 32'(cur_duty), 32'd100);

    // start together with abort stays idle
    step_cyc();
    start = 1'b1;
    abort = 1'b1;
    step_cyc();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("sa_busy", 32'(busy), 32'd0);
    chk("sa_cs", 32'(csr_cs), 32'd0);
    step_cyc();
    chk_en = 1'b1;

    // 5a: step 0 jumps straight to target
    run(1, 100, 0, 0, 0, 3, 1'b0);
    chk("t5a_cur", 32'(cur_duty), 32'd0);

    // 5b: abort during the wait after duty 20
    d0 = ndone;
    cfg_divisor = 16'd1;
    cfg_period = 16'd100;
    cfg_ctrl = 8'd0;
    target_duty = 16'd40;
    step = 16'd10;
    interval = 16'd3;
    start = 1'b1;
    s = cyc;
    plan(s, 1, 100, 0, 40, 10, 3);
    truncate(s + 9);
    step_cyc();
    start = 1'b0;
    while (cyc < s + 9) step_cyc();
    abort = 1'b1;
    step_cyc();
    abort = 1'b0;
    repeat (8) step_cyc();
    @(negedge clk);
    chk("t5b_cur", 32'(cur_duty), 32'd20);
    chk("t5b_model_cur", 32'(model_cur), 32'd20);
    chk("t5b_no_done", 32'(ndone - d0), 32'd0);
    step_cyc();

    // 6: asynchronous reset during a duty write
    chk_en = 1'b0;
    target_duty = 16'd90;
    step = 16'd5;
    start = 1'b1;
    s = cyc;
    step_cyc();
    start = 1'b0;
    while (cyc < s + 4) step_cyc();
    @(negedge clk);
    chk("t6_pre_cs", 32'(csr_cs), 32'd1);
    chk("t6_pre_data", 32'(csr_wdata), 32'd25);
    #1 reset = 1'b1;
    #1;
    chk("t6_cs", 32'(csr_cs), 32'd0);
    chk("t6_we", 32'(csr_we), 32'd0);
    chk("t6_addr", 32'(csr_addr), 32'd0);
    chk("t6_wdata", 32'(csr_wdata), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_cur", 32'(cur_duty), 32'd0);
    repeat (2) step_cyc();
    reset = 1'b0;
    step_cyc();
    @(negedge clk);
    chk("t6_post_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
